// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: FSM encoding,
// write-source codes, and the datapath widths common to the EX/WB register
// and the register file.
package rf_write_arbiter_pkg;

   // Datapath widths shared with EX/WB and the register file
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int OPC_W  = 2;

   // Arbiter FSM states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   // rf_src encoding
   localparam logic SRC_PIPE = 1'b0;
   localparam logic SRC_HOST = 1'b1;

endpackage

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. The pipeline write-back always wins
// except in the single forced-stall cycle; a host request starved for
// STARVE_LIMIT consecutive cycles forces that stall so the host gets a slot.
// All rf_* outputs and host_ack are registered (1-cycle latency for both
// sources); stall_pipe decodes the state register only.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int DATA_W_P     = DATA_W,
   parameter int ADDR_W_P     = ADDR_W,
   parameter int OPC_W_P      = OPC_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic                wb_we,
   input  logic [ADDR_W_P-1:0] wb_addr,
   input  logic [DATA_W_P-1:0] wb_data,
   input  logic [OPC_W_P-1:0]  wb_opcode,
   input  logic                host_req,
   input  logic [ADDR_W_P-1:0] host_addr,
   input  logic [DATA_W_P-1:0] host_data,
   output logic                host_ack,
   output logic                stall_pipe,
   output logic                rf_we,
   output logic [ADDR_W_P-1:0] rf_addr,
   output logic [DATA_W_P-1:0] rf_data,
   output logic                rf_src,
   output logic [OPC_W_P-1:0]  rf_opcode,
   output logic                collision_err
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W:0]   LIMIT_X = (CNT_W + 1)'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W:0]   cnt_inc;
   logic             host_grant;
   logic             pipe_acc;

   // Stall is purely a state decode so it cannot loop back through wb_we
   assign stall_pipe = (state == ST_STALL);

   // The pipeline write is dropped only in the forced-stall cycle
   assign pipe_acc = wb_we && (state != ST_STALL);

   // One extra bit so the increment can be compared before saturating
   assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

   // Next-state, starvation counter and host-grant decision
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      host_grant = 1'b0;
      case (state)
         ST_IDLE: begin
            if (host_req) begin
               if (!wb_we) begin
                  host_grant = 1'b1;
                  state_nxt  = ST_ACK;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (!host_req) begin
               // host withdrew without an ack: forget the starvation history
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (!wb_we) begin
               host_grant = 1'b1;
               state_nxt  = ST_ACK;
               cnt_nxt    = '0;
            end else begin
               if (cnt_inc >= LIMIT_X) begin
                  state_nxt = ST_STALL;
                  cnt_nxt   = LIMIT_C;
               end else begin
                  cnt_nxt = cnt_inc[CNT_W-1:0];
               end
            end
         end
         ST_STALL: begin
            host_grant = 1'b1;
            state_nxt  = ST_ACK;
            cnt_nxt    = '0;
         end
         default: begin
            // ST_ACK: host write is on the port now; host_req is ignored
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM and counter registers
   always_ff @(posedge clk) begin
      if (Reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Registered write port; grant and pipeline accept never coincide because
   // a grant needs wb_we=0 or the stall cycle, where wb_we is ignored
   always_ff @(posedge clk) begin
      if (Reset) begin
         rf_we     <= 1'b0;
         rf_addr   <= '0;
         rf_data   <= '0;
         rf_src    <= SRC_PIPE;
         rf_opcode <= '0;
         host_ack  <= 1'b0;
      end else begin
         host_ack <= host_grant;
         rf_we    <= host_grant || pipe_acc;
         if (host_grant) begin
            rf_addr   <= host_addr;
            rf_data   <= host_data;
            rf_src    <= SRC_HOST;
            rf_opcode <= '0;
         end else if (pipe_acc) begin
            rf_addr   <= wb_addr;
            rf_data   <= wb_data;
            rf_src    <= SRC_PIPE;
            rf_opcode <= wb_opcode;
         end else begin
            rf_addr   <= '0;
            rf_data   <= '0;
            rf_src    <= SRC_PIPE;
            rf_opcode <= '0;
         end
      end
   end

   // Sticky flag: the pipeline ignored the stall and its write was lost
   always_ff @(posedge clk) begin
      if (Reset) collision_err <= 1'b0;
      else if (stall_pipe && wb_we) collision_err <= 1'b1;
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter. Each table row is one
// clock cycle: the inputs driven in that cycle and the outputs expected to be
// visible in that same cycle (registered from the previous edge).
module tb_rf_write_arbiter;

   logic       clk = 1'b0;
   logic       Reset;
   logic       wb_we;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic [1:0] wb_opcode;
   logic       host_req;
   logic [2:0] host_addr;
   logic [7:0] host_data;
   logic       host_ack, stall_pipe, rf_we, rf_src, collision_err;
   logic [2:0] rf_addr;
   logic [7:0] rf_data;
   logic [1:0] rf_opcode;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .Reset(Reset),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_opcode(wb_opcode),
      .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
      .host_ack(host_ack), .stall_pipe(stall_pipe),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
      .rf_src(rf_src), .rf_opcode(rf_opcode), .collision_err(collision_err)
   );

   // ek: 0 = no write, 1 = pipeline write, 2 = host write, 3 = everything zero
   typedef struct {
      logic       chk;
      logic       rst, we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic [1:0] wo;
      logic       hr;
      logic [2:0] ha;
      logic [7:0] hd;
      int         ek;
      logic [2:0] ea;
      logic [7:0] ed;
      logic [1:0] eo;
      logic       est, ece;
   } row_t;

   row_t rows[$];

   function automatic row_t mk(input logic rst, we, input logic [2:0] wa,
                               input logic [7:0] wd, input logic [1:0] wo,
                               input logic hr, input logic [2:0] ha,
                               input logic [7:0] hd, input int ek,
                               input logic [2:0] ea, input logic [7:0] ed,
                               input logic [1:0] eo, input logic est, ece);
      row_t r;
      r.chk = 1'b1; r.rst = rst; r.we = we; r.wa = wa; r.wd = wd; r.wo = wo;
      r.hr = hr; r.ha = ha; r.hd = hd; r.ek = ek; r.ea = ea; r.ed = ed;
      r.eo = eo; r.est = est; r.ece = ece;
      return r;
   endfunction

   task automatic check(input string name, input logic ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got we=%0b a=%0d d=%h src=%0b op=%0d ack=%0b stall=%0b cerr=%0b",
                  name, rf_we, rf_addr, rf_data, rf_src, rf_opcode, host_ack,
                  stall_pipe, collision_err);
      end
   endtask

   function automatic logic row_ok(input row_t r);
      logic ok;
      ok = (stall_pipe === r.est) && (collision_err === r.ece);
      case (r.ek)
         1: ok = ok && rf_we === 1'b1 && host_ack === 1'b0 && rf_src === 1'b0 &&
                 rf_addr === r.ea && rf_data === r.ed && rf_opcode === r.eo;
         2: ok = ok && rf_we === 1'b1 && host_ack === 1'b1 && rf_src === 1'b1 &&
                 rf_addr === r.ea && rf_data === r.ed && rf_opcode === 2'd0;
         3: ok = ok && rf_we === 1'b0 && host_ack === 1'b0 && rf_src === 1'b0 &&
                 rf_addr === 3'd0 && rf_data === 8'd0 && rf_opcode === 2'd0;
         default: ok = ok && rf_we === 1'b0 && host_ack === 1'b0;
      endcase
      return ok;
   endfunction

   initial begin
      int ack_at, stalls;
      row_t r;
      Reset = 1'b1; wb_we = 1'b1; wb_addr = 3'd2; wb_data = 8'h11; wb_opcode = 2'd0;
      host_req = 1'b0; host_addr = 3'd0; host_data = 8'h00;

      //                rst we wa  wd     wo hr ha  hd     ek ea  ed     eo st ce
      // reset with wb_we=1, then first cycle after reset
      r = mk(1, 1, 2, 8'h11, 0, 0, 0, 8'h00, 3, 0, 8'h00, 0, 0, 0); r.chk = 0; rows.push_back(r);
      rows.push_back(mk(1, 1, 2, 8'h11, 0, 1, 0, 8'h00, 3, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 3, 0, 8'h00, 0, 0, 0));
      // idle host write
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 1, 5, 8'hA7, 0, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2, 5, 8'hA7, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
      // starvation with wb_we held through the stall -> collision
      rows.push_back(mk(0, 1, 2, 8'h3C, 2, 1, 6, 8'h55, 0, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 1, 2, 8'h3C, 2, 1, 6, 8'h55, 1, 2, 8'h3C, 2, 0, 0));
      rows.push_back(mk(0, 1, 2, 8'h3C, 2, 1, 6, 8'h55, 1, 2, 8'h3C, 2, 0, 0));
      rows.push_back(mk(0, 1, 2, 8'h3C, 2, 1, 6, 8'h55, 1, 2, 8'h3C, 2, 0, 0));
      rows.push_back(mk(0, 1, 2, 8'h3C, 2, 1, 6, 8'h55, 1, 2, 8'h3C, 2, 1, 0));
      rows.push_back(mk(0, 1, 2, 8'h3C, 2, 0, 0, 8'h00, 2, 6, 8'h55, 0, 0, 1));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 2, 8'h3C, 2, 0, 1));
      // reset clears the sticky flag
      rows.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1));
      // starvation, pipeline honours the stall: no collision, no lost write
      rows.push_back(mk(0, 1, 1, 8'h21, 1, 1, 7, 8'h9E, 3, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 1, 1, 8'h22, 1, 1, 7, 8'h9E, 1, 1, 8'h21, 1, 0, 0));
      rows.push_back(mk(0, 1, 1, 8'h23, 1, 1, 7, 8'h9E, 1, 1, 8'h22, 1, 0, 0));
      rows.push_back(mk(0, 1, 1, 8'h24, 1, 1, 7, 8'h9E, 1, 1, 8'h23, 1, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 1, 7, 8'h9E, 1, 1, 8'h24, 1, 1, 0));
      rows.push_back(mk(0, 1, 1, 8'h25, 1, 0, 0, 8'h00, 2, 7, 8'h9E, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 8'h25, 1, 0, 0));
      // blocked 2 cycles, then granted without a stall
      rows.push_back(mk(0, 1, 3, 8'h40, 3, 1, 4, 8'h66, 0, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 1, 3, 8'h41, 3, 1, 4, 8'h66, 1, 3, 8'h40, 3, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 1, 4, 8'h66, 1, 3, 8'h41, 3, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2, 4, 8'h66, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
      // second request granted immediately
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h77, 0, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2, 0, 8'h77, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
      // reset while in WAIT with cnt=3 (a leftover count would stall here)
      rows.push_back(mk(0, 1, 5, 8'h50, 0, 1, 2, 8'hC3, 0, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 1, 5, 8'h51, 0, 1, 2, 8'hC3, 1, 5, 8'h50, 0, 0, 0));
      rows.push_back(mk(0, 1, 5, 8'h52, 0, 1, 2, 8'hC3, 1, 5, 8'h51, 0, 0, 0));
      rows.push_back(mk(1, 1, 5, 8'h53, 0, 1, 2, 8'hC3, 1, 5, 8'h52, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 1, 2, 8'hC3, 3, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2, 2, 8'hC3, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
      // host drops request while waiting: back to idle, no ack
      rows.push_back(mk(0, 1, 6, 8'h60, 0, 1, 3, 8'h33, 0, 0, 8'h00, 0, 0, 0));
      rows.push_back(mk(0, 1, 6, 8'h61, 0, 0, 0, 8'h00, 1, 6, 8'h60, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 6, 8'h61, 0, 0, 0));
      rows.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));

      foreach (rows[i]) begin
         @(negedge clk);
         Reset = rows[i].rst; wb_we = rows[i].we; wb_addr = rows[i].wa;
         wb_data = rows[i].wd; wb_opcode = rows[i].wo; host_req = rows[i].hr;
         host_addr = rows[i].ha; host_data = rows[i].hd;
         #1;
         if (rows[i].chk) check($sformatf("row%0d", i), row_ok(rows[i]));
      end

      // Hand sequence: pipeline never yields; host must still be served
      // after four blocked cycles, with exactly one stall cycle on the way.
      @(negedge clk);
      wb_we = 1'b1; wb_addr = 3'd3; wb_data = 8'h11; wb_opcode = 2'd1;
      host_req = 1'b1; host_addr = 3'd1; host_data = 8'hEE;
      ack_at = 0; stalls = 0;
      for (int k = 1; k <= 12 && ack_at == 0; k++) begin
         @(negedge clk); #1;
         if (stall_pipe) stalls++;
         if (host_ack) begin
            ack_at = k;
            host_req = 1'b0;
            check("starve_ack_data", rf_we === 1'b1 && rf_src === 1'b1 &&
                  rf_addr === 3'd1 && rf_data === 8'hEE);
         end
      end
      if (ack_at == 0) begin
         failures++; checks++;
         $display("FAIL starve_timeout: got no host_ack in 12 cycles, want one");
      end
      checks++;
      if (ack_at != 5) begin
         failures++;
         $display("FAIL starve_latency: got ack at cycle %0d, want 5", ack_at);
      end
      checks++;
      if (stalls != 1) begin
         failures++;
         $display("FAIL stall_count: got %0d stall cycles, want 1", stalls);
      end
      check("collision_sticky", collision_err === 1'b1);
      @(negedge clk);
      wb_we = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
